kapisma_turnuva: RTL
====================

KAPISMA_TURNUVA -- requirements
Module: kapisma_turnuva

Interface
REQ-001 Parameter OYUNCU, default 3: number of players, legal range 2..8.
REQ-002 Parameter TUR, default 4: rounds per match, legal range 1..15.
REQ-003 Parameter PUAN_W, default 12: width of the accumulated match score.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 basla  input  1  match-start pulse.
REQ-007 gecerli  input  1  round data valid.
REQ-008 hazir  output  1  block ready to accept round data.
REQ-009 sag_adimlar  input  2*OYUNCU  right steps; player k (1..OYUNCU) uses bits [2k-1:2k-2].
REQ-010 asagi_adimlar  input  2*OYUNCU  down steps, same packing.
REQ-011 sayi  input  4  target number for the round, legal 1..9.
REQ-012 tur_gecerli  output  1  one-cycle pulse: round result valid.
REQ-013 tur_kazanan  output  4  round winner (1..OYUNCU), 0 = none.
REQ-014 tur_puan  output  7  round score.
REQ-015 toplam_puan  output  PUAN_W  accumulated match score.
REQ-016 hata  output  1  one-cycle pulse: round rejected.
REQ-017 mac_bitti  output  1  match complete.
REQ-018 mac_kazanan  output  4  match winner, 0 = none.

Function
REQ-019 Guess per player: sag and asagi each clamped to max 2; tahmin = 3*asagi + sag + 1 (range 1..9); correct when tahmin == sayi.
REQ-020 Round winner = lowest-index correct player; 0 if no player is correct.
REQ-021 pozitif = sum of correct guesses; negatif = sum of wrong guesses; tur_puan = pozitif - negatif if pozitif > negatif, else 0.
REQ-022 FSM states: BOSTA, BEKLE, HESAP, BITTI.
REQ-023 BOSTA: hazir = 0; basla -> BEKLE, clearing the round counter, toplam_puan and all per-player win counters.
REQ-024 BEKLE: hazir = 1; gecerli && hazir latches sag_adimlar, asagi_adimlar and sayi, then -> HESAP.
REQ-025 HESAP: hazir = 0; lasts one cycle; results register at its end; tur_gecerli pulses in the following cycle (acceptance to tur_gecerli = 2 cycles).
REQ-026 Result registers tur_kazanan and tur_puan hold until the next valid round or a new basla.
REQ-027 Valid round effects:
- toplam_puan += tur_puan, saturating at 2^PUAN_W - 1;
- winner's win counter increments;
- round counter increments.
REQ-028 Latched sayi 0 or >9: round rejected; hata pulses in place of tur_gecerli; no counter, score or result register changes; return to BEKLE.
REQ-029 After round TUR completes -> BITTI: mac_bitti = 1, hazir = 0.
REQ-030 mac_kazanan = player with the most round wins; ties go to the lowest index; 0 if all counters are zero. Updated on entry to BITTI.
REQ-031 BITTI holds all outputs until basla, which behaves as REQ-023 and clears mac_bitti and mac_kazanan.
REQ-032 basla and gecerli together in BEKLE: basla wins; the match restarts and the data is discarded.
REQ-033 basla during HESAP: ignored.
REQ-034 gecerli outside BEKLE: ignored.

Reset
REQ-035 rst_n low immediately forces:
- state to BOSTA;
- all outputs and counters to 0 (hazir = 0, tur_gecerli = 0, hata = 0, mac_bitti = 0);
- this applies in any state, including mid-HESAP.
REQ-036 After rst_n deasserts, no activity until basla.

Verification (OYUNCU=3, TUR=2)
REQ-037 basla; round sag=0x21, asagi=0x21, sayi=5 -> guesses 5,1,9; tur_gecerli 2 cycles after acceptance; tur_kazanan=1; tur_puan=0; toplam_puan=0.
REQ-038 Round sag=0x15, asagi=0x15, sayi=5 -> all guesses 5; tur_kazanan=1; tur_puan=15; toplam_puan=15; mac_bitti=1; mac_kazanan=1 (2 wins).
REQ-039 basla; round sag=0x3F, asagi=0x3F, sayi=9 -> clamp gives all guesses 9; tur_puan=27; round sag=0x00, asagi=0x00, sayi=2 -> tur_kazanan=0, tur_puan=0, toplam_puan=27, mac_kazanan=1.
REQ-040 Round with sayi=0 and then sayi=12 -> hata pulses each time; round count and toplam_puan unchanged; hazir returns to 1.
REQ-041 basla and gecerli together in BEKLE after one round -> counters clear; data ignored; toplam_puan=0.
REQ-042 rst_n low during HESAP -> all outputs 0 asynchronously; no tur_gecerli afterwards; state BOSTA.

Source files
------------

// File: rtl/kapisma_turnuva.sv
// Multi-player grid-guessing tournament: each round scores every player's guess against a
// target number, tracks the round winner and running score, and names a match winner.
module kapisma_turnuva #(
  parameter int unsigned OYUNCU = 3,
  parameter int unsigned TUR    = 4,
  parameter int unsigned PUAN_W = 12
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                basla,
  input  logic                gecerli,
  output logic                hazir,
  input  logic [2*OYUNCU-1:0] sag_adimlar,
  input  logic [2*OYUNCU-1:0] asagi_adimlar,
  input  logic [3:0]          sayi,
  output logic                tur_gecerli,
  output logic [3:0]          tur_kazanan,
  output logic [6:0]          tur_puan,
  output logic [PUAN_W-1:0]   toplam_puan,
  output logic                hata,
  output logic                mac_bitti,
  output logic [3:0]          mac_kazanan
);

  typedef enum logic [1:0] {StBosta, StBekle, StHesap, StBitti} durum_e;

  durum_e durum_q, durum_d;

  logic [2*OYUNCU-1:0] sag_q, sag_d, asagi_q, asagi_d;
  logic [3:0]          sayi_q, sayi_d;
  logic [3:0]          tur_sayac_q, tur_sayac_d;
  logic [3:0]          galibiyet_q [OYUNCU];
  logic [3:0]          galibiyet_d [OYUNCU];
  logic                tur_gecerli_d, hata_d, mac_bitti_d;
  logic [3:0]          tur_kazanan_d, mac_kazanan_d;
  logic [6:0]          tur_puan_d;
  logic [PUAN_W-1:0]   toplam_puan_d;

  // Round evaluation on the latched data
  logic [1:0]        sag_k, asagi_k;
  logic [3:0]        tahmin;
  logic [6:0]        pozitif, negatif, puan;
  logic [3:0]        kazanan;
  logic [3:0]        galibiyet_yeni [OYUNCU];
  logic [3:0]        en_iyi, en_iyi_sayi;
  logic [PUAN_W:0]   toplam_genis;
  logic [PUAN_W-1:0] toplam_doygun;
  logic              sayi_hatali;

  always_comb begin
    pozitif = '0;
    negatif = '0;
    kazanan = '0;
    sag_k   = '0;
    asagi_k = '0;
    tahmin  = '0;
    for (int k = OYUNCU - 1; k >= 0; k--) begin
      sag_k   = (sag_q[2*k +: 2] == 2'd3) ? 2'd2 : sag_q[2*k +: 2];
      asagi_k = (asagi_q[2*k +: 2] == 2'd3) ? 2'd2 : asagi_q[2*k +: 2];
      tahmin  = 4'd3 * {2'b00, asagi_k} + {2'b00, sag_k} + 4'd1;
      if (tahmin == sayi_q) begin
        pozitif = pozitif + {3'b000, tahmin};
        kazanan = 4'(k + 1);
      end else begin
        negatif = negatif + {3'b000, tahmin};
      end
    end
    puan = (pozitif > negatif) ? (pozitif - negatif) : 7'd0;

    en_iyi      = '0;
    en_iyi_sayi = '0;
    for (int k = 0; k < OYUNCU; k++) begin
      galibiyet_yeni[k] = galibiyet_q[k] + ((kazanan == 4'(k + 1)) ? 4'd1 : 4'd0);
      // Strict compare keeps ties on the lowest index and yields 0 when nobody won
      if (galibiyet_yeni[k] > en_iyi_sayi) begin
        en_iyi_sayi = galibiyet_yeni[k];
        en_iyi      = 4'(k + 1);
      end
    end

    toplam_genis  = {1'b0, toplam_puan} + (PUAN_W + 1)'(puan);
    toplam_doygun = toplam_genis[PUAN_W] ? {PUAN_W{1'b1}} : toplam_genis[PUAN_W-1:0];
    sayi_hatali   = (sayi_q == 4'd0) || (sayi_q > 4'd9);
  end

  always_comb begin
    durum_d       = durum_q;
    sag_d         = sag_q;
    asagi_d       = asagi_q;
    sayi_d        = sayi_q;
    tur_sayac_d   = tur_sayac_q;
    tur_gecerli_d = 1'b0;
    hata_d        = 1'b0;
    tur_kazanan_d = tur_kazanan;
    tur_puan_d    = tur_puan;
    toplam_puan_d = toplam_puan;
    mac_bitti_d   = mac_bitti;
    mac_kazanan_d = mac_kazanan;
    for (int k = 0; k < OYUNCU; k++) galibiyet_d[k] = galibiyet_q[k];

    if (basla && (durum_q != StHesap)) begin
      durum_d       = StBekle;
      tur_sayac_d   = '0;
      tur_kazanan_d = '0;
      tur_puan_d    = '0;
      toplam_puan_d = '0;
      mac_bitti_d   = 1'b0;
      mac_kazanan_d = '0;
      for (int k = 0; k < OYUNCU; k++) galibiyet_d[k] = '0;
    end else begin
      unique case (durum_q)
        StBekle: begin
          if (gecerli) begin
            sag_d   = sag_adimlar;
            asagi_d = asagi_adimlar;
            sayi_d  = sayi;
            durum_d = StHesap;
          end
        end
        StHesap: begin
          if (sayi_hatali) begin
            hata_d  = 1'b1;
            durum_d = StBekle;
          end else begin
            tur_gecerli_d = 1'b1;
            tur_kazanan_d = kazanan;
            tur_puan_d    = puan;
            toplam_puan_d = toplam_doygun;
            tur_sayac_d   = tur_sayac_q + 4'd1;
            for (int k = 0; k < OYUNCU; k++) galibiyet_d[k] = galibiyet_yeni[k];
            if (tur_sayac_q + 4'd1 == 4'(TUR)) begin
              durum_d       = StBitti;
              mac_bitti_d   = 1'b1;
              mac_kazanan_d = en_iyi;
            end else begin
              durum_d = StBekle;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign hazir = (durum_q == StBekle);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      durum_q <= StBosta;
    end else begin
      durum_q <= durum_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sag_q       <= '0;
      asagi_q     <= '0;
      sayi_q      <= '0;
      tur_sayac_q <= '0;
      tur_gecerli <= 1'b0;
      hata        <= 1'b0;
      tur_kazanan <= '0;
      tur_puan    <= '0;
      toplam_puan <= '0;
      mac_bitti   <= 1'b0;
      mac_kazanan <= '0;
      for (int k = 0; k < OYUNCU; k++) galibiyet_q[k] <= '0;
    end else begin
      sag_q       <= sag_d;
      asagi_q     <= asagi_d;
      sayi_q      <= sayi_d;
      tur_sayac_q <= tur_sayac_d;
      tur_gecerli <= tur_gecerli_d;
      hata        <= hata_d;
      tur_kazanan <= tur_kazanan_d;
      tur_puan    <= tur_puan_d;
      toplam_puan <= toplam_puan_d;
      mac_bitti   <= mac_bitti_d;
      mac_kazanan <= mac_kazanan_d;
      for (int k = 0; k < OYUNCU; k++) galibiyet_q[k] <= galibiyet_d[k];
    end
  end

endmodule
